ioblock_oserdes: RTL

//  Output-direction companion to the pad input cell: accepts a parallel word on a

---
 rtl/ioblock_oserdes_if.sv | 38 +++
 rtl/ioblock_oserdes.sv | 139 +++++++++++++
 2 files changed

// File: rtl/ioblock_oserdes_if.sv
// ioblock_oserdes_if
//   Fabric-side bundle for the output serializer. Fabric logic offers a parallel
//   word and a tri-state mode on a valid/ready handshake. The block reports when it
//   can take a word and whether a frame is being sent.
// Signals
//   DATA    [WIDTH-1:0]  word to send, sampled at the handshake edge
//   VALID                DATA is valid
//   READY                block can accept a word (handshake = VALID & READY at posedge)
//   OEMODE  [1:0]        00 pad never driven, 01 driven only in a frame, 1x always driven
//   BUSY                 frame in progress
// Modports
//   master  fabric side (drives DATA/VALID/OEMODE)
//   slave   serializer side (drives READY/BUSY)
interface ioblock_oserdes_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] DATA;
    logic             VALID;
    logic             READY;
    logic [1:0]       OEMODE;
    logic             BUSY;

    modport master (
        output DATA,
        output VALID,
        output OEMODE,
        input  READY,
        input  BUSY
    );

    modport slave (
        input  DATA,
        input  VALID,
        input  OEMODE,
        output READY,
        output BUSY
    );
endinterface

// File: rtl/ioblock_oserdes.sv
// ioblock_oserdes
//   Output-direction pad serializer. Takes a parallel word on a valid/ready
//   handshake and sends it LSB first on the pad. Each frame is TS_LEAD cycles of
//   idle level '1', then WIDTH data bits, then TS_TAIL cycles of '1'. Both the pad
//   value and the pad enable come straight from flops.
// Parameters
//   WIDTH    bits per word (2..32)
//   TS_LEAD  idle-level cycles before bit 0 (0..7)
//   TS_TAIL  idle-level cycles after the last bit (0..7)
// Ports
//   IOCLK    clock, all state updates on posedge
//   IORST_N  asynchronous active-low reset
//   bus      slave side of ioblock_oserdes_if (DATA, VALID, READY, OEMODE, BUSY)
//   PIN      bidirectional pad, out_q when oe_q=1, otherwise released
module ioblock_oserdes #(
    parameter int WIDTH   = 8,
    parameter int TS_LEAD = 1,
    parameter int TS_TAIL = 1
) (
    input  logic              IOCLK,
    input  logic              IORST_N,
    ioblock_oserdes_if.slave  bus,
    inout  wire               PIN
);

    localparam int CW = $clog2(WIDTH + 8);

    // Terminal counts per phase; the counter is cleared on every phase change.
    // The guards keep a zero-length phase from producing a negative constant;
    // such a phase is skipped by the FSM and its terminal count is never used.
    localparam logic [CW-1:0] LEAD_LAST = CW'((TS_LEAD > 0) ? TS_LEAD - 1 : 0);
    localparam logic [CW-1:0] BIT_LAST  = CW'(WIDTH - 1);
    localparam logic [CW-1:0] TAIL_LAST = CW'((TS_TAIL > 0) ? TS_TAIL - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        SHIFT = 2'd2,
        TAIL  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             oe_q, oe_d;
    logic [1:0]       mode_q, mode_d;

    always_ff @(posedge IOCLK or negedge IORST_N) begin
        if (!IORST_N) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            out_q   <= 1'b1;
            oe_q    <= 1'b0;
            mode_q  <= 2'b01;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            oe_q    <= oe_d;
            mode_q  <= mode_d;
        end
    end

    // out_d is the value the pad shows during the cycle after this edge, so the
    // bit to send is taken from the shift register (or DATA when there is no lead
    // phase) on the same edge that enters or advances SHIFT.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        out_d   = 1'b1;
        mode_d  = mode_q;

        case (state_q)
            IDLE: begin
                mode_d = bus.OEMODE;
                if (bus.VALID) begin
                    cnt_d = '0;
                    if (TS_LEAD == 0) begin
                        state_d = SHIFT;
                        out_d   = bus.DATA[0];
                        shift_d = bus.DATA >> 1;
                    end else begin
                        state_d = LEAD;
                        shift_d = bus.DATA;
                    end
                end
            end
            LEAD: begin
                if (cnt_q == LEAD_LAST) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    out_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_q == BIT_LAST) begin
                    state_d = (TS_TAIL == 0) ? IDLE : TAIL;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    out_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            TAIL: begin
                if (cnt_q == TAIL_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Enable is decoded from the mode and state that will hold after this
        // edge so that the enable flop lines up with the value flop.
        case (mode_d)
            2'b00:   oe_d = 1'b0;
            2'b01:   oe_d = (state_d != IDLE);
            default: oe_d = 1'b1;
        endcase
    end

    assign bus.READY = (state_q == IDLE);
    assign bus.BUSY  = (state_q != IDLE);
    assign PIN       = oe_q ? out_q : 1'bz;

endmodule
